fft_frame_scheduler: RTL and testbench

- Sequences the FFT controller over successive capture frames for the energy detector.
- Serves two ping-pong capture buffers in strict alternation and pulses the FFT controller's ready input once per frame.
- Tags each frame as first/last of a NUM_AVG-frame averaging window for the squared-magnitude accumulator.
- Holds the averaged result until the detector acknowledges it; a watchdog catches a hung FFT.

---
 rtl/fft_sched_pkg.sv | 26 ++
 rtl/fft_frame_scheduler_if.sv | 32 +++
 rtl/fft_watchdog.sv | 26 ++
 rtl/fft_frame_scheduler.sv | 138 +++++++++++++
 tb/tb_fft_frame_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and defaults for the FFT frame scheduler.
// Holds the FSM encoding, default sizing constants and the width helper.
package fft_sched_pkg;

  localparam int DEF_NUM_AVG = 16;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_START    = 3'd2,
    S_BUSY     = 3'd3,
    S_RELEASE  = 3'd4,
    S_HOLD     = 3'd5,
    S_ERROR    = 3'd6
  } sched_state_t;

  // Smallest r with 2**r >= v; callers pass N+1 so that 2**r > N.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Buffer, FFT-controller, accumulator and detector signals of the frame scheduler.
// The master side is the scheduler; the slave side is the surrounding datapath.
interface fft_frame_scheduler_if
  import fft_sched_pkg::*;
#(
  parameter int CNT_W = clog2(DEF_NUM_AVG + 1)
);
  logic [1:0]       buf_full;
  logic [1:0]       buf_release;
  logic             buf_sel;
  logic             fft_start;
  logic             fft_abort;
  logic             fft_frame_done;
  logic             acc_first;
  logic             acc_last;
  logic [CNT_W-1:0] frame_cnt;
  logic             result_valid;
  logic             result_ack;
  logic             error;

  modport master (
    input  buf_full, fft_frame_done, result_ack,
    output buf_release, buf_sel, fft_start, fft_abort, acc_first, acc_last,
           frame_cnt, result_valid, error
  );

  modport slave (
    output buf_full, fft_frame_done, result_ack,
    input  buf_release, buf_sel, fft_start, fft_abort, acc_first, acc_last,
           frame_cnt, result_valid, error
  );
endinterface

// File: rtl/fft_watchdog.sv
// Cycle counter that flags a hung FFT; tc asserts once the count reaches TIMEOUT-1.
// Held at zero while clear is high, counts while en is high.
module fft_watchdog #(
  parameter int TIMEOUT = 4096,
  parameter int TMR_W   = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + TMR_W'(1);
    end
  end

  assign tc = (count >= TC_VAL);
endmodule

// File: rtl/fft_frame_scheduler.sv
// Drives the FFT controller frame by frame from two ping-pong buffers, tagging averaging windows.
// fft_start 1 cycle after buf_full, buf_release/result_valid 1 cycle after done; stalls in HOLD until result_ack.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int NUM_AVG = DEF_NUM_AVG,
  parameter int CNT_W   = clog2(NUM_AVG + 1),
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = clog2(TIMEOUT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  fft_frame_scheduler_if.master bus
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_AVG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_AVG - 1);

  sched_state_t     state;
  logic             next_buf;
  logic [1:0]       buf_release;
  logic             buf_sel;
  logic             fft_start;
  logic             fft_abort;
  logic             acc_first;
  logic             acc_last;
  logic [CNT_W-1:0] frame_cnt;
  logic             result_valid;
  logic             error;
  logic             wd_run;
  logic             wd_tc;

  // The watchdog runs from the START cycle so the abort lands TIMEOUT cycles after fft_start.
  assign wd_run = (state == S_START) || (state == S_BUSY);

  fft_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clear (!wd_run),
    .en    (wd_run),
    .tc    (wd_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      next_buf     <= 1'b0;
      buf_release  <= 2'b00;
      buf_sel      <= 1'b0;
      fft_start    <= 1'b0;
      fft_abort    <= 1'b0;
      acc_first    <= 1'b0;
      acc_last     <= 1'b0;
      frame_cnt    <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      fft_start   <= 1'b0;
      fft_abort   <= 1'b0;
      buf_release <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (enable) state <= S_WAIT_BUF;
        end
        S_WAIT_BUF: begin
          if (!enable) begin
            state     <= S_IDLE;
            frame_cnt <= '0;
            next_buf  <= 1'b0;
          end else if (bus.buf_full[next_buf]) begin
            // Window tags go out with fft_start and stay up for the whole frame.
            buf_sel   <= next_buf;
            fft_start <= 1'b1;
            acc_first <= (frame_cnt == '0);
            acc_last  <= (frame_cnt == CNT_LAST);
            state     <= S_START;
          end
        end
        S_START: begin
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (bus.fft_frame_done) begin
            buf_release <= buf_sel ? 2'b10 : 2'b01;
            next_buf    <= ~next_buf;
            acc_first   <= 1'b0;
            acc_last    <= 1'b0;
            if (acc_last) begin
              frame_cnt    <= CNT_FULL;
              result_valid <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
            state <= S_RELEASE;
          end else if (wd_tc) begin
            fft_abort    <= 1'b1;
            error        <= 1'b1;
            buf_sel      <= 1'b0;
            acc_first    <= 1'b0;
            acc_last     <= 1'b0;
            frame_cnt    <= '0;
            result_valid <= 1'b0;
            state        <= S_ERROR;
          end
        end
        S_RELEASE: begin
          state <= result_valid ? S_HOLD : S_WAIT_BUF;
        end
        S_HOLD: begin
          if (bus.result_ack) begin
            result_valid <= 1'b0;
            frame_cnt    <= '0;
            state        <= S_WAIT_BUF;
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.buf_release  = buf_release;
  assign bus.buf_sel      = buf_sel;
  assign bus.fft_start    = fft_start;
  assign bus.fft_abort    = fft_abort;
  assign bus.acc_first    = acc_first;
  assign bus.acc_last     = acc_last;
  assign bus.frame_cnt    = frame_cnt;
  assign bus.result_valid = result_valid;
  assign bus.error        = error;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with NUM_AVG=4, TIMEOUT=64.
module tb_fft_frame_scheduler;
  localparam int NUM_AVG = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 3;

  logic clock;
  logic reset;
  logic enable;
  int   n_checks;
  int   n_err;

  fft_frame_scheduler_if #(.CNT_W(CNT_W)) bus ();

  fft_frame_scheduler #(
    .NUM_AVG (NUM_AVG),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_start(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.fft_start) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Called in the fft_start cycle; done arrives 20 cycles later, checks the release cycle.
  task automatic finish_frame(input int sel, input int first, input int cnt, input int rv);
    tick(19);
    check("acc_first_held", 32'(bus.acc_first), 32'(first));
    bus.fft_frame_done = 1'b1;
    tick(1);
    bus.fft_frame_done = 1'b0;
    check("buf_release", 32'(bus.buf_release), 32'(1 << sel));
    check("frame_cnt", 32'(bus.frame_cnt), 32'(cnt));
    check("result_valid", 32'(bus.result_valid), 32'(rv));
    check("acc_first_clr", 32'(bus.acc_first), 32'd0);
  endtask

  task automatic do_frame(input int sel, input int first, input int last, input int cnt, input int rv);
    wait_start("start_seen");
    check("buf_sel", 32'(bus.buf_sel), 32'(sel));
    check("acc_first", 32'(bus.acc_first), 32'(first));
    check("acc_last", 32'(bus.acc_last), 32'(last));
    finish_frame(sel, first, cnt, rv);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_release"}, 32'(bus.buf_release), 32'd0);
    check({tag, "_sel"}, 32'(bus.buf_sel), 32'd0);
    check({tag, "_start"}, 32'(bus.fft_start), 32'd0);
    check({tag, "_abort"}, 32'(bus.fft_abort), 32'd0);
    check({tag, "_first"}, 32'(bus.acc_first), 32'd0);
    check({tag, "_last"}, 32'(bus.acc_last), 32'd0);
    check({tag, "_cnt"}, 32'(bus.frame_cnt), 32'd0);
    check({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_err"}, 32'(bus.error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int starts;
    int drops;
    int k;
    n_checks = 0;
    n_err    = 0;
    reset = 1'b0;
    enable = 1'b0;
    bus.buf_full = 2'b00;
    bus.fft_frame_done = 1'b0;
    bus.result_ack = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b1;

    // Full window: buffers filled alternately.
    enable = 1'b1;
    for (int f = 0; f < NUM_AVG; f++) begin
      bus.buf_full = 2'(1 << (f % 2));
      do_frame(f % 2, (f == 0) ? 1 : 0, (f == NUM_AVG - 1) ? 1 : 0,
               (f == NUM_AVG - 1) ? NUM_AVG : f + 1, (f == NUM_AVG - 1) ? 1 : 0);
    end

    // Result held while the detector stalls; both buffers stay full.
    bus.buf_full = 2'b11;
    starts = 0;
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.fft_start) starts++;
      if (!bus.result_valid) drops++;
    end
    check("hold_no_start", 32'(starts), 32'd0);
    check("hold_rv_drops", 32'(drops), 32'd0);
    bus.result_ack = 1'b1;
    tick(1);
    bus.result_ack = 1'b0;
    check("ack_rv", 32'(bus.result_valid), 32'd0);
    check("ack_cnt", 32'(bus.frame_cnt), 32'd0);
    tick(1);
    check("ack_start", 32'(bus.fft_start), 32'd1);
    check("ack_sel", 32'(bus.buf_sel), 32'd0);
    check("ack_first", 32'(bus.acc_first), 32'd1);
    finish_frame(0, 1, 1, 0);

    // Enable dropped mid second frame: IDLE at the next WAIT_BUF, window discarded.
    wait_start("start_f1");
    check("f1_sel", 32'(bus.buf_sel), 32'd1);
    enable = 1'b0;
    finish_frame(1, 0, 2, 0);
    tick(3);
    check("dis_cnt", 32'(bus.frame_cnt), 32'd0);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.fft_start) starts++;
    end
    check("dis_no_start", 32'(starts), 32'd0);
    enable = 1'b1;
    wait_start("restart");
    check("restart_sel", 32'(bus.buf_sel), 32'd0);
    check("restart_first", 32'(bus.acc_first), 32'd1);

    // No done: watchdog aborts TIMEOUT cycles after fft_start.
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (bus.fft_abort) begin
        k = i;
        break;
      end
    end
    check("abort_delay", 32'(k), 32'(TIMEOUT));
    check("abort_err", 32'(bus.error), 32'd1);
    check("abort_first", 32'(bus.acc_first), 32'd0);
    tick(1);
    check("abort_pulse", 32'(bus.fft_abort), 32'd0);
    bus.fft_frame_done = 1'b1;
    enable = 1'b0;
    tick(1);
    bus.fft_frame_done = 1'b0;
    enable = 1'b1;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.fft_start || bus.buf_release != 2'b00) starts++;
    end
    check("err_quiet", 32'(starts), 32'd0);
    check("err_sticky", 32'(bus.error), 32'd1);

    reset = 1'b0;
    enable = 1'b0;
    bus.buf_full = 2'b00;
    tick(2);
    check("reset2_err", 32'(bus.error), 32'd0);
    reset = 1'b1;

    // Wrong buffer alone never starts a frame.
    enable = 1'b1;
    bus.buf_full = 2'b10;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.fft_start) starts++;
    end
    check("alt_no_start", 32'(starts), 32'd0);
    bus.buf_full = 2'b11;
    tick(1);
    check("alt_start", 32'(bus.fft_start), 32'd1);
    check("alt_sel", 32'(bus.buf_sel), 32'd0);

    // Reset in BUSY, then a late done must be ignored.
    tick(5);
    reset = 1'b0;
    tick(1);
    check_all_zero("busy_rst");
    reset = 1'b1;
    enable = 1'b0;
    bus.fft_frame_done = 1'b1;
    tick(1);
    bus.fft_frame_done = 1'b0;
    tick(1);
    check("late_done_rel", 32'(bus.buf_release), 32'd0);
    check("late_done_rv", 32'(bus.result_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
